// File: rtl/seq_mul32.sv
// Sequential unsigned 32x32 -> 64-bit shift-add multiplier.
// It retires one partial-product step per clock through a shared ripple adder.

module add_all (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 31; i++) begin
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    sum = a ^ b ^ c;
  end

  // cout is the carry into bit 31, not out of it; it is kept for existing callers.
  assign cout = c[31];
endmodule

module seq_mul32 #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              busy,
  output logic              done,
  output logic [2*N-1:0]    product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;

  logic [N-1:0]     hi, addend, sum;
  logic             co, add_cout_unused;
  logic [2*N-1:0]   step;

  assign hi     = acc_q[2*N-1:N];
  assign addend = acc_q[0] ? mcand_q : '0;

  add_all u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  // True carry out of bit 31, rebuilt from the operand and sum MSBs; it is 0 when addend is 0.
  assign co   = (hi[N-1] & addend[N-1]) | ((hi[N-1] ^ addend[N-1]) & ~sum[N-1]);
  assign step = {co, sum, acc_q[N-1:1]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{N{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          product_d = step;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32: vector table, random products against a*b,
// and hand-written sequences for ignored starts, mid-run reset and back-to-back starts.

module tb_seq_mul32;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  seq_mul32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;
  int overlap     = 0;
  logic [63:0] last_product;

  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
    if (busy === 1'b1 && done === 1'b1) overlap++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [63:0] exp, input string name);
    int run_bad;
    int pulses0;
    run_bad = 0;
    pulses0 = done_pulses;
    a = op_a;
    b = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!(busy === 1'b1 && done === 1'b0 && product === last_product)) run_bad++;
      a = $urandom;
      b = $urandom;
      tick();
    end
    check({name, " run cycles"}, 64'(run_bad), 64'd0);
    check({name, " done"}, 64'({busy, done}), 64'b01);
    check({name, " product"}, product, exp);
    last_product = exp;
    tick();
    check({name, " done drop"}, 64'({busy, done}), 64'b00);
    check({name, " held"}, product, exp);
    check({name, " pulses"}, 64'(done_pulses - pulses0), 64'd1);
  endtask

  initial begin
    int p0, n, found, bad;
    int t, first_done_t, second_t;
    logic prev_busy;
    logic [63:0] prod1, prod2;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, "3x5"};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, "max x max"};
    vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, "msb x 2"};
    vecs[3] = '{32'd0,          32'hFFFF_FFFF,  64'h0,                   "0 x max"};
    vecs[4] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, "max x 1"};
    vecs[5] = '{32'd1,          32'h8000_0000,  64'h0000_0000_8000_0000, "1 x msb"};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    last_product = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(busy === 1'b0 && done === 1'b0 && product === 64'd0)) bad++;
    end
    check("idle stable", 64'(bad), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, {32'd0, ra} * {32'd0, rb}, "random");
    end

    // start raised during RUN and still high through DONE must be ignored.
    p0 = done_pulses;
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1;
    a = 32'd1;
    b = 32'd1;
    found = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      a = $urandom;
      b = $urandom;
    end
    check("ignored-start done seen", 64'(found), 64'd1);
    check("ignored-start latency", 64'(n), 64'd23);
    check("ignored-start product", product, 64'h3F);
    tick();
    start = 1'b0;
    check("start in DONE ignored", 64'({busy, done}), 64'b00);
    for (int i = 0; i < 3; i++) tick();
    check("ignored-start pulses", 64'(done_pulses - p0), 64'd1);
    check("ignored-start held", product, 64'h3F);
    last_product = 64'h3F;

    // Reset in the middle of a run aborts without a done pulse.
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-reset busy", 64'(busy), 64'd0);
    check("mid-reset done", 64'(done), 64'd0);
    check("mid-reset product", product, 64'd0);
    last_product = '0;
    p0 = done_pulses;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("mid-reset stays idle", 64'(bad), 64'd0);
    check("mid-reset no pulse", 64'(done_pulses - p0), 64'd0);
    run_op(32'd2, 32'd3, 64'd6, "post-reset 2x3");

    // start held high: two operations, the second accepted only from IDLE.
    p0 = done_pulses;
    a = 32'd0;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    check("b2b first accept", 64'(busy), 64'd1);
    a = 32'h10;
    b = 32'h10;
    prev_busy = 1'b1;
    first_done_t = -1;
    second_t = -1;
    prod1 = '1;
    prod2 = '1;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      t++;
      if (done === 1'b1 && first_done_t < 0) begin
        first_done_t = t;
        prod1 = product;
      end else if (done === 1'b1 && second_t >= 0) begin
        prod2 = product;
        break;
      end
      if (busy === 1'b1 && prev_busy === 1'b0 && first_done_t >= 0 && second_t < 0) begin
        second_t = t;
        start = 1'b0;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("b2b first product", prod1, 64'd0);
    check("b2b second product", prod2, 64'h100);
    check("b2b accept gap", 64'(second_t - first_done_t), 64'd2);
    check("b2b pulses", 64'(done_pulses - p0), 64'd2);
    check("b2b final idle", 64'({busy, done}), 64'b00);

    check("busy/done exclusive", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_mul32.md
Name: seq_mul32

Overview:
Sequential unsigned 32x32 -> 64-bit shift-add multiplier for the ALU datapath. It produces one partial-product step per clock. Each step goes through a single instance of the team's 32-bit ripple adder, add_all, with carry-in tied to 0. The block uses a start/busy/done handshake and holds its result until the next operation.

Parameters:
N, 32, operand width; fixed at 32 to match add_all; no other value supported
CW, 6, step-counter width; must hold 0..N

Ports:
clk      input   1   rising-edge clock
rst      input   1   synchronous, active-high reset
start    input   1   request a multiply; sampled only in IDLE
a        input   32  multiplicand; sampled with start
b        input   32  multiplier; sampled with start
busy     output  1   high while an operation is in progress (RUN)
done     output  1   one-cycle pulse when product becomes valid
product  output  64  unsigned a*b; held stable from done until next accepted start

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst is sampled on the rising edge and overrides all other inputs.
  - On reset: state=IDLE, busy=0, done=0, product=0, counter=0, internal registers cleared.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- Internal registers: mcand[31:0], acc[63:0] (hi=acc[63:32], lo=acc[31:0]), cnt[CW-1:0].
- States:
  - IDLE:
    - busy=0, done=0.
    - start=1 at edge k: mcand<=a, acc<={32'b0,b}, cnt<=0, state<=RUN.
    - start=0: remain in IDLE.
  - RUN:
    - busy=1.
    - Each edge: if acc[0]=1, add_all computes s = hi + mcand; otherwise s = hi.
    - Carry-out co (1 bit): the add_all cout port is the carry INTO bit 31 and must not be used. Derive co = (hi[31]&mcand[31]) | ((hi[31]^mcand[31]) & ~s[31]). co=0 when no add is performed.
    - acc <= {co, s, lo[31:1]}; cnt <= cnt+1.
    - When cnt==31 at the edge: perform the final step, then state<=DONE.
  - DONE:
    - busy=0, done=1 for exactly this one cycle.
    - product register is loaded from acc on the edge entering DONE, so product is valid during the done cycle.
    - Next edge: state<=IDLE.
- Latency:
  - start sampled at edge k -> busy=1 after edge k.
  - 32 steps occur on edges k+1..k+32.
  - done=1 in the cycle after edge k+32; done drops and the block is back in IDLE after edge k+33.
  - Next start is accepted at edge k+34 at the earliest.
- start handling:
  - start asserted in RUN or DONE is ignored; it is not queued.
  - a and b are don't-care outside the accepting edge. Changing them during RUN must not affect the result.
- product:
  - Updated only on entry to DONE.
  - Retains its value through IDLE and the entire following RUN.
- Arithmetic:
  - Purely unsigned; no overflow is possible in 64 bits.
  - acc[63] at the end is the true MSB of the product.
- busy and done are mutually exclusive in all states.

Test Plan:
- Reset with rst=1 for 2 cycles, then deassert -> busy=0, done=0, product=0x0000000000000000; idle for 5 cycles with start=0 -> no change.
- a=3, b=5, start pulsed at edge k -> busy=1 for 32 cycles; done=1 in exactly one cycle after edge k+32; product=0x000000000000000F; done=0 the following cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (exercises the derived carry-out); repeat with a=0x80000000, b=2 -> product=0x0000000100000000.
- Start 7*9, then on step 10 assert start with a=1, b=1 and change a/b every cycle -> request ignored, product=0x000000000000003F, only one done pulse.
- Start 0x12345678*0x9ABCDEF0, then assert rst at step 15 -> next cycle busy=0, done=0, product=0, state IDLE, no done pulse; a new 2*3 then yields product=6.
- Back-to-back: hold start=1 continuously with a=0, b=0xFFFFFFFF, then a=0x10, b=0x10 -> product=0 then 0x100; exactly two done pulses; second start accepted only in IDLE.
